imem_loader: RTL and testbench
==============================

# imem_loader

Write-side companion to the instruction ROM: receives a byte stream over a valid/ready handshake, packs it little-endian into 32-bit ARM instruction words and writes them into the instruction-memory write port at word-aligned byte addresses 0x00, 0x04, … 0xFC. It holds the processor core off (`cpu_hold`) for the whole load so program images can be replaced without resynthesis. It sits between the board-level byte source (UART/JTAG bridge) and the instruction RAM.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory byte-address width.
- `DATA_W`, 32: instruction word width; fixed at 4 bytes.
- `MAX_WORDS`, 64: capacity in words, 2^ADDR_W / 4.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; sampled only in IDLE.
- `word_count`  in  7  number of words to load; latched on accepted `start`.
- `abort`  in  1  cancel the load in progress; sampled in LOAD and WRITE.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  next image byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_W  byte address, always a multiple of 4.
- `mem_wdata`  out  DATA_W  packed instruction word.
- `cpu_hold`  out  1  core must stall/reset while high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last word has been written.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: `start`=1 latches `word_count`. A value above 64 is clamped to 64. The word index and byte index are cleared. The next state is LOAD, or DONE directly when the count is 0, with no writes.
- LOAD: `byte_ready`=1. A byte is accepted on `byte_valid && byte_ready` at the clock edge.
  - Byte k (0..3) goes to `mem_wdata[8k+7:8k]`, so the first byte is the LSB.
  - After the 4th accepted byte the next state is WRITE.
- WRITE: `byte_ready`=0, `mem_we`=1, `mem_addr` = word_index*4, `mem_wdata` holds the packed word.
  - Next state is DONE if word_index+1 == count. Otherwise word_index increments, byte_index clears, and the next state is LOAD.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `cpu_hold` = 1 in LOAD, WRITE and DONE; it drops in the cycle IDLE is re-entered.
- `abort` in LOAD or WRITE: go to IDLE next cycle.
  - If `abort` is high in the same cycle as `mem_we`, that write still happens; it is already on the port.
  - No further writes; the partial word is discarded and `done` is not pulsed.
- `start` outside IDLE is ignored. A byte presented outside LOAD is not accepted (`byte_ready`=0).
- `mem_addr` never wraps: with count ≤ 64 the maximum address is 0xFC.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE. All outputs are 0: `byte_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_hold`, `busy`, `done`.
- Reset mid-load aborts immediately. Memory contents already written stay as they are.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- `start` at edge t: `busy`, `cpu_hold` and `byte_ready` are high from t+1.
- With `byte_valid` held high, one word takes 5 cycles (4 accept + 1 write).
  - N words: the last `mem_we` occurs at t+5N; `done` at t+5N+1; IDLE at t+5N+2.
- Gaps in `byte_valid` simply stretch LOAD; byte order is preserved.

## Structure
- Package `imem_pkg`:
  - `IMEM_ADDR_W`=8, `IMEM_WORDS`=64, `INSTR_W`=32.
  - `loader_state_t` enum {IDLE, LOAD, WRITE, DONE}.
  - This package is shared with the instruction ROM/RAM and the fetch stage.
- Sub-module `byte_packer`:
  - 2-bit byte counter plus a 32-bit little-endian assembly register.
  - Outputs `word_full`; inputs `accept` and `clear`.
- The top level holds the FSM, the word counter and the latched count.

## Test plan
- Reset: drive `rst_n` low mid-LOAD. All outputs go to 0 asynchronously and the state is IDLE, with no `mem_we` afterwards.
- Single word: `word_count`=1, bytes 0x02,0x1A,0xA0,0xE3 back-to-back. Expect exactly one `mem_we` with addr 0x00 and data 0xE3A01A02, `done` at cycle t+6, and `cpu_hold` low at t+7.
- Full image: `word_count`=64 with random valid gaps. Expect 64 writes at addresses 0x00..0xFC in order, data matching the packed stream, and no wrap.
- Boundaries:
  - `word_count`=0 gives `done` with no writes.
  - `word_count`=100 is clamped to 64 writes.
  - `start` pulsed mid-load is ignored.
- Abort: assert `abort` after 2 words plus 3 bytes. Expect exactly 2 writes (0x00, 0x04), no `done`, IDLE on the next cycle, `cpu_hold`=0, and `byte_ready`=0 thereafter.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: geometry of the instruction RAM/ROM
// and the loader state encoding, plus the word-count clamp used by the loader.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_WORDS  = 64;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Limit a requested word count to the memory capacity so the
    // write address can never wrap past the last word.
    function automatic logic [6:0] clamp_count(input logic [6:0] n, input int max_words);
        return (int'(n) > max_words) ? 7'(max_words) : n;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte assembler: the k-th accepted byte lands in byte lane k
// of the output word. word_full flags the accept that completes a word.
module byte_packer
    import imem_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic              word_full,
    output logic [DATA_W-1:0] word
);

    localparam int LANES = DATA_W / 8;

    logic [1:0] byte_idx_reg;

    // Byte counter: position of the next byte within the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg <= '0;
        end else if (clear) begin
            byte_idx_reg <= '0;
        end else if (accept) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

    assign word_full = accept && (byte_idx_reg == 2'(LANES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Lane gi captures the byte accepted while the counter points at it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (clear) begin
                    lane_reg <= '0;
                end else if (accept && (byte_idx_reg == 2'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte stream, packs it into 32-bit
// words and writes them to consecutive word addresses while holding the core.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = INSTR_W,
    parameter int MAX_WORDS = IMEM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = ADDR_W - 2;

    loader_state_t     state_reg, state_next;
    logic [IDX_W-1:0]  word_idx_reg;
    logic [6:0]        count_reg;
    logic [6:0]        clamped_count;
    logic              start_load;
    logic              next_word;
    logic              packer_clear;
    logic              accept;
    logic              word_full;
    logic              last_word;
    logic [DATA_W-1:0] packed_word;

    assign clamped_count = clamp_count(word_count, MAX_WORDS);
    assign accept        = (state_reg == LOAD) && byte_valid;
    assign last_word     = ((7'(word_idx_reg) + 7'd1) == count_reg);

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (packer_clear),
        .accept    (accept),
        .byte_data (byte_data),
        .word_full (word_full),
        .word      (packed_word)
    );

    // State register plus latched word count and current word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            word_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_load) begin
                count_reg    <= clamped_count;
                word_idx_reg <= '0;
            end else if (next_word) begin
                word_idx_reg <= word_idx_reg + 1'b1;
            end
        end
    end

    // Next-state logic; abort wins over progress in LOAD and WRITE.
    always_comb begin
        state_next   = state_reg;
        start_load   = 1'b0;
        next_word    = 1'b0;
        packer_clear = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    start_load   = 1'b1;
                    packer_clear = 1'b1;
                    state_next   = (clamped_count == 7'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    packer_clear = 1'b1;
                    state_next   = IDLE;
                end else if (word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    packer_clear = 1'b1;
                    state_next   = IDLE;
                end else if (last_word) begin
                    state_next = DONE;
                end else begin
                    next_word    = 1'b1;
                    packer_clear = 1'b1;
                    state_next   = LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state; address/data are zero off-write.
    assign byte_ready = (state_reg == LOAD);
    assign mem_we     = (state_reg == WRITE);
    assign mem_addr   = (state_reg == WRITE) ? {word_idx_reg, 2'b00} : '0;
    assign mem_wdata  = (state_reg == WRITE) ? packed_word : '0;
    assign busy       = (state_reg != IDLE);
    assign cpu_hold   = (state_reg != IDLE);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a
// monitor pops and compares on every mem_we, done pulses are counted.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  word_count;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img[$];
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .DATA_W(32), .MAX_WORDS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    $display("write addr=0x%02h data=0x%08h", mem_addr, mem_wdata);
                    check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                    check("wr_data", mem_wdata, e.data);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Reference model: n = min(count, 64) words, word w at address 4w made
    // of bytes 4w..4w+3 with the earliest byte in the least significant lane.
    task automatic build_image(input int count);
        int n;
        n = (count > 64) ? 64 : count;
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = 8'(4 * w);
            e.data = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_start(input int count);
        start      = 1'b1;
        word_count = 7'(count);
        step(1);
        start      = 1'b0;
    endtask

    task automatic drive_bytes(input int nbytes, input bit gaps);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < nbytes && cyc < 4000) begin
            byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            byte_data  = img[idx];
            @(negedge clk);
            acc = byte_valid && byte_ready;
            step(1);
            if (acc) idx++;
            cyc++;
        end
        byte_valid = 1'b0;
        check("bytes_sent", idx, nbytes);
    endtask

    task automatic finish_load(input int base);
        for (int i = 0; i < 40 && done_cnt == base; i++) step(1);
        check("done_pulses", done_cnt, base + 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_hold", cpu_hold, 0);
        check("writes_left", exp_q.size(), 0);
        step(1);
    endtask

    task automatic run_load(input int count, input bit gaps, input bit mid_start);
        int base;
        int n;
        n = (count > 64) ? 64 : count;
        $display("load count=%0d gaps=%0d mid_start=%0d", count, gaps, mid_start);
        build_image(count);
        base = done_cnt;
        issue_start(count);
        fork
            drive_bytes(4 * n, gaps);
            if (mid_start) begin
                step(12);
                start      = 1'b1;
                word_count = 7'd1;
                step(1);
                start      = 1'b0;
            end
        join
        finish_load(base);
    endtask

    task automatic run_abort(input int count, input int nbytes, input int keep);
        int base;
        $display("abort count=%0d after %0d bytes", count, nbytes);
        build_image(count);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        base = done_cnt;
        issue_start(count);
        drive_bytes(nbytes, 1'b1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_hold", cpu_hold, 0);
        check("abort_ready", byte_ready, 0);
        byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_ready_after", byte_ready, 0);
        end
        byte_valid = 1'b0;
        check("abort_no_done", done_cnt, base);
        check("abort_writes_left", exp_q.size(), 0);
        step(1);
    endtask

    initial begin
        int base;
        rst_n      = 1'b1;
        start      = 1'b0;
        word_count = '0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;

        // Power-on reset.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Single word with cycle-exact timing; edge t samples start.
        $display("single word timing");
        begin
            wr_t e;
            e.addr = 8'h00;
            e.data = 32'hE3A0_1A02;
            exp_q.push_back(e);
        end
        base       = done_cnt;
        byte_valid = 1'b1;
        byte_data  = 8'h02;
        start      = 1'b1;
        word_count = 7'd1;
        step(1);
        start = 1'b0;
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_hold", cpu_hold, 1);
        check("t1_ready", byte_ready, 1);
        step(1); byte_data = 8'h1A;
        step(1); byte_data = 8'hA0;
        step(1); byte_data = 8'hE3;
        @(negedge clk);
        check("t4_we", mem_we, 0);
        step(1); byte_valid = 1'b0;
        @(negedge clk);
        check("t5_we", mem_we, 1);
        check("t5_ready", byte_ready, 0);
        step(1);
        @(negedge clk);
        check("t6_done", done, 1);
        check("t6_we", mem_we, 0);
        step(1);
        @(negedge clk);
        check("t7_done", done, 0);
        check("t7_hold", cpu_hold, 0);
        check("single_done_pulses", done_cnt, base + 1);
        check("single_writes_left", exp_q.size(), 0);
        step(1);

        // Main function and boundaries.
        run_load(0, 1'b0, 1'b0);
        run_load(3, 1'b0, 1'b0);
        run_load(7, 1'b1, 1'b0);
        run_load(10, 1'b1, 1'b1);
        run_load(64, 1'b1, 1'b0);
        run_load(100, 1'b0, 1'b0);

        // Abort mid-word and abort coinciding with a write.
        run_abort(5, 11, 2);
        run_abort(4, 8, 2);

        // Asynchronous reset in the middle of the second word.
        $display("reset mid-load");
        build_image(3);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        issue_start(3);
        drive_bytes(6, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", byte_ready, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        byte_valid = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(10);
        byte_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_writes_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
